// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver: 8N1 frames, held result with ready/error flags until rd_ack.
// Optional UART_RX_PARITY_EN adds an even-parity bit (8E1) and the parity_err output.
module uart_rx_16x #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 brclk,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int       BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]    MID   = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0]    LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, brclk_q;
  logic                 armed_q, armed_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif
  logic                 tick, sample, complete;

  assign tick     = brclk & ~brclk_q;
  assign sample   = tick && (tick_cnt_q == LAST);
  assign complete = (state_q == STOP) && sample;

  // State register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE:   if (!rx_s_q && armed_q) state_d = START;
        START:  if (tick_cnt_q == MID)  state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (sample && bit_cnt_q == BLAST) state_d = PARITY;
        PARITY: if (sample) state_d = STOP;
`else
        DATA:   if (sample && bit_cnt_q == BLAST) state_d = STOP;
`endif
        STOP:   if (sample) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif
    if (tick) begin
      if (state_q == IDLE || (state_q == START && tick_cnt_q == MID)) tick_cnt_d = 4'd0;
      else                                                            tick_cnt_d = tick_cnt_q + 4'd1;
      if (rx_s_q) armed_d = 1'b1;
    end
    if (state_q == START) bit_cnt_d = '0;
    if (state_q == DATA && sample) begin
      shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + BW'(1);
    end
`ifdef UART_RX_PARITY_EN
    if (state_q == PARITY && sample) par_d = rx_s_q;
`endif
    // A completing byte overrides a coincident rd_ack; the ack only retires the old overrun.
    if (complete) begin
      rx_data_d   = shift_q;
      frame_err_d = ~rx_s_q;
      rx_ready_d  = 1'b1;
      overrun_d   = (overrun_q | rx_ready_q) & ~rd_ack;
      if (!rx_s_q) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = (^shift_q) ^ par_q;
`endif
    end else if (rd_ack) begin
      rx_ready_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      brclk_q     <= 1'b0;
      armed_q     <= 1'b0;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      brclk_q     <= brclk;
      armed_q     <= armed_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Bench for uart_rx_16x: vector table, directed corner sequences, randomized frames vs a frame-level model.
module tb_uart_rx_16x;
  logic       sysclk = 1'b0, reset = 1'b1, brclk = 1'b0, rx = 1'b1, rd_ack = 1'b0, br_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int DONE_TICKS = 168;
`else
  localparam int DONE_TICKS = 152;
`endif
  int errors = 0, checks = 0;

  uart_rx_16x dut (
    .sysclk(sysclk), .reset(reset), .brclk(brclk), .rx(rx), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 sysclk = ~sysclk;
  // brclk period = 4 sysclk, edges on sysclk falling edges
  always #20 if (br_en) brclk = ~brclk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_br(input int n);
    repeat (n) @(posedge brclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip, input logic end_lvl);
    rx = 1'b0; wait_br(16);
    for (int i = 0; i < 8; i++) begin rx = d[i]; wait_br(16); end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ pflip; wait_br(16);
`else
    if (pflip) rx = 1'b0;
`endif
    rx = stop; wait_br(16);
    rx = end_lvl;
  endtask

  task automatic do_ack();
    @(posedge sysclk); #1 rd_ack = 1'b1;
    @(posedge sysclk); #1 rd_ack = 1'b0;
  endtask

  task automatic check_all(input string p, input logic [7:0] d, input logic rdy, input logic fe,
                           input logic ov, input logic pe);
    @(negedge sysclk);
    chk({p, ".data"}, rx_data, d);
    chk({p, ".ready"}, rx_ready, rdy);
    chk({p, ".frame_err"}, frame_err, fe);
    chk({p, ".overrun"}, overrun_err, ov);
    chk({p, ".busy"}, busy, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk({p, ".parity_err"}, parity_err, pe);
`else
    if (pe === 1'bx) chk({p, ".pe_x"}, 1'b0, 1'b1);
`endif
  endtask

  typedef struct {
    logic [7:0] d; logic stop; logic pflip; logic ack;
    logic [7:0] e_data; logic e_rdy; logic e_fe; logic e_ov; logic e_pe;
  } vec_t;
  vec_t tbl[9];

  // Frame-level reference model
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ov, m_pe;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (5) @(posedge sysclk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wait_br(4);

    foreach (tbl[i]) begin
      if (tbl[i].ack) do_ack();
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].pflip, 1'b1);
      wait_br(16);
      check_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_rdy, tbl[i].e_fe, tbl[i].e_ov, tbl[i].e_pe);
    end

    // rd_ack clears ready on the next edge only; rx_data retained
    @(posedge sysclk); #1 rd_ack = 1'b1;
    @(negedge sysclk); chk("ack.before_edge", rx_ready, 1'b1);
    @(posedge sysclk); #1 rd_ack = 1'b0;
    chk("ack.ready", rx_ready, 1'b0);
    chk("ack.data", rx_data, 8'h07);
    do_ack();
    check_all("ack.idle", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

    // False start: 4 ticks low
    rx = 1'b0; wait_br(4); rx = 1'b1; wait_br(24);
    check_all("false_start", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1); wait_br(16);
    check_all("after_false", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad stop followed by a 20-bit break
    do_ack();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    check_all("break.frame", 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_br(16); do_ack(); wait_br(320);
    check_all("break.held", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1; wait_br(16);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1); wait_br(16);
    check_all("break.after", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overrun, then rd_ack coinciding with completion of a third byte
    do_ack();
    send_frame(8'h11, 1'b1, 1'b0, 1'b1); wait_br(16);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1); wait_br(16);
    check_all("ovr.set", 8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    fork
      send_frame(8'h33, 1'b1, 1'b0, 1'b1);
      begin
        int n = 0;
        while (!busy && n < 4000) begin @(posedge sysclk); #1; n++; end
        chk("ovr.start_seen", busy, 1'b1);
        if (busy) begin
          repeat (DONE_TICKS*4 - 1) @(posedge sysclk);
          #1 rd_ack = 1'b1;
          chk("ovr.busy_pre", busy, 1'b1);
          @(posedge sysclk); #1 rd_ack = 1'b0;
          chk("ovr.busy_post", busy, 1'b0);
          chk("ovr.ready", rx_ready, 1'b1);
          chk("ovr.cleared", overrun_err, 1'b0);
          chk("ovr.data", rx_data, 8'h33);
        end
      end
    join
    wait_br(16);
    check_all("ovr.final", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during bit 4 of 0xC6
    fork
      send_frame(8'hC6, 1'b1, 1'b0, 1'b1);
      begin
        wait_br(16*5 + 8);
        @(negedge sysclk);
        chk("rst.busy_pre", busy, 1'b1);
        reset = 1'b1; #1;
        chk("rst.data", rx_data, 8'h00);
        chk("rst.ready", rx_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
      end
    join
    @(negedge sysclk); reset = 1'b0;
    wait_br(16);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1); wait_br(16);
    check_all("rst.after", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // brclk stopped mid-frame: receiver waits, then resumes
    do_ack();
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      begin
        wait_br(16*3 + 4);
        br_en = 1'b0;
        repeat (200) @(posedge sysclk);
        @(negedge sysclk);
        chk("freeze.busy", busy, 1'b1);
        chk("freeze.ready", rx_ready, 1'b0);
        br_en = 1'b1;
      end
    join
    wait_br(16);
    check_all("freeze.after", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the model
    m_data = 8'h5A; m_rdy = 1'b1; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic stop, pflip, ack;
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      pflip = ($urandom_range(0, 3) == 0);
      ack   = 1'($urandom_range(0, 1));
      if (ack) begin
        do_ack();
        m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
      end
      send_frame(d, stop, pflip, 1'b1);
      m_ov = m_ov | m_rdy; m_rdy = 1'b1; m_data = d; m_fe = ~stop;
`ifdef UART_RX_PARITY_EN
      m_pe = pflip;
`endif
      wait_br(16);
      check_all($sformatf("rand%0d", i), m_data, m_rdy, m_fe, m_ov, m_pe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
